// File: rtl/spram_16k16.sv
// 16K x 16 single-port RAM with nibble write masks, standby/sleep/poweroff; SPRAM_WRITE_READBACK_EN adds read-before-write on data_out.
// Latency: read data registered, valid one cycle after the address edge.
// Backpressure: none; every enabled edge completes an access.
module spram_16k16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] address,
    input  logic [15:0] data_in,
    input  logic [3:0]  mask_wren,
    input  logic        wren,
    input  logic        chipselect,
    input  logic        standby,
    input  logic        sleep,
    input  logic        poweroff,
    output logic [15:0] data_out
);

    logic [15:0]    mem_q [16384];
    // Per-word valid bits let poweroff wipe the whole array in one edge;
    // a word whose bit is clear reads as zero regardless of mem_q.
    logic [16383:0] vld_q = '0;
    logic [15:0]    data_out_q = '0;
    logic [15:0]    data_out_d;
    logic [15:0]    rd_word;
    logic [15:0]    wr_word;
    logic           wr_en;
    logic           wipe;

    always_comb begin
        rd_word = mem_q[address] & {16{vld_q[address]}};
        for (int i = 0; i < 4; i++) begin
            wr_word[4*i +: 4] = mask_wren[i] ? data_in[4*i +: 4] : rd_word[4*i +: 4];
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        wr_en      = 1'b0;
        wipe       = 1'b0;
        if (!poweroff) begin
            data_out_d = '0;
            wipe       = 1'b1;
        end else if (sleep) begin
            data_out_d = '0;
        end else if (standby || !chipselect) begin
            data_out_d = data_out_q;
        end else if (!wren) begin
            data_out_d = rd_word;
        end else begin
            wr_en = 1'b1;
`ifdef SPRAM_WRITE_READBACK_EN
            data_out_d = rd_word;
`else
            data_out_d = data_out_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            if (wipe) begin
                vld_q <= '0;
            end else if (wr_en) begin
                mem_q[address] <= wr_word;
                vld_q[address] <= 1'b1;
            end
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_spram_16k16.sv
// Directed scoreboard bench for spram_16k16: stimulus queues expected data_out per edge, a negedge monitor checks it.
module tb_spram_16k16;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] address;
    logic [15:0] data_in;
    logic [3:0]  mask_wren;
    logic        wren;
    logic        chipselect;
    logic        standby;
    logic        sleep;
    logic        poweroff;
    logic [15:0] data_out;

    typedef struct {
        int          cyc;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spram_16k16 dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data_in   (data_in),
        .mask_wren (mask_wren),
        .wren      (wren),
        .chipselect(chipselect),
        .standby   (standby),
        .sleep     (sleep),
        .poweroff  (poweroff),
        .data_out  (data_out)
    );

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            tests++;
            if (q[0].cyc != cyc) begin
                fails++;
                $display("FAIL %s: check missed at cycle %0d, due %0d", q[0].name, cyc, q[0].cyc);
            end else if (data_out !== q[0].exp) begin
                fails++;
                $display("FAIL %s: data_out got %h expected %h", q[0].name, data_out, q[0].exp);
            end
            void'(q.pop_front());
        end
    end

    // One clocked access; exp is data_out required just after this edge.
    task automatic op(input logic rst, input logic pwr, input logic slp, input logic sb,
                      input logic cs, input logic we, input logic [13:0] a,
                      input logic [15:0] d, input logic [3:0] m,
                      input logic [15:0] exp, input string nm);
        exp_t e;
        reset = rst; poweroff = pwr; sleep = slp; standby = sb;
        chipselect = cs; wren = we; address = a; data_in = d; mask_wren = m;
        e.cyc = cyc + 1; e.exp = exp; e.name = nm;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [13:0] a, input logic [15:0] exp, input string nm);
        op(0, 1, 0, 0, 1, 0, a, 16'h0, 4'h0, exp, nm);
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m,
                      input logic [15:0] exp, input string nm);
        op(0, 1, 0, 0, 1, 1, a, d, m, exp, nm);
    endtask

    localparam bit RB =
`ifdef SPRAM_WRITE_READBACK_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        reset = 1'b1; poweroff = 1'b1; sleep = 1'b0; standby = 1'b0;
        chipselect = 1'b0; wren = 1'b0; address = '0; data_in = '0; mask_wren = '0;
        @(negedge clk);
        op(1, 1, 0, 0, 0, 0, 14'h0, 16'h0, 4'h0, 16'h0000, "reset_state");

        wr(14'h0005, 16'h1234, 4'hF, 16'h0000, "wr5_dout");
        rd(14'h0005, 16'h1234, "rd5");
        rd(14'h3FFF, 16'h0000, "rd3fff_unwritten");

        wr(14'h0010, 16'hFFFF, 4'hF, 16'h0000, "wr10_ffff_dout");
        wr(14'h0010, 16'hABCD, 4'h5, RB ? 16'hFFFF : 16'h0000, "wr10_mask0101_dout");
        rd(14'h0010, 16'hFBFD, "rd10_masked");
        wr(14'h0010, 16'h0000, 4'h0, 16'hFBFD, "wr10_mask0000_dout");
        rd(14'h0010, 16'hFBFD, "rd10_after_nullwrite");

        rd(14'h0005, 16'h1234, "ctl_rd5");
        op(0, 1, 0, 1, 1, 0, 14'h0010, 16'h0, 4'h0, 16'h1234, "standby_read_hold");
        op(0, 1, 0, 1, 1, 1, 14'h0005, 16'h0000, 4'hF, 16'h1234, "standby_write_hold");
        op(0, 1, 1, 1, 1, 0, 14'h0005, 16'h0, 4'h0, 16'h0000, "sleep_zero");
        op(0, 1, 1, 0, 1, 1, 14'h0005, 16'h9999, 4'hF, 16'h0000, "sleep_write_zero");
        rd(14'h0005, 16'h1234, "wake_rd5");
        op(0, 1, 0, 0, 0, 0, 14'h0010, 16'h0, 4'h0, 16'h1234, "cs0_hold");

        rd(14'h0010, 16'hFBFD, "b2b_rd10");
        rd(14'h0005, 16'h1234, "b2b_rd5");

        wr(14'h0006, 16'h1111, 4'hF, RB ? 16'h0000 : 16'h1234, "wr6_dout");
        rd(14'h0006, 16'h1111, "wr_then_rd6");
        wr(14'h0005, 16'h2222, 4'hF, RB ? 16'h1234 : 16'h1111, "write_readback");
        rd(14'h0005, 16'h2222, "rd5_2222");

        wr(14'h0005, 16'h1234, 4'hF, RB ? 16'h2222 : 16'h2222, "wr5_restore");
        rd(14'h0005, 16'h1234, "rd5_restored");
        op(1, 1, 0, 0, 1, 1, 14'h0005, 16'h5555, 4'hF, 16'h0000, "reset_with_write");
        rd(14'h0005, 16'h1234, "rd5_after_reset");

        op(0, 0, 0, 0, 1, 1, 14'h0006, 16'h7777, 4'hF, 16'h0000, "poweroff_dout");
        rd(14'h0005, 16'h0000, "rd5_after_poweroff");
        rd(14'h0006, 16'h0000, "rd6_poweroff_write");
        rd(14'h0010, 16'h0000, "rd10_after_poweroff");
        wr(14'h0007, 16'hCDAB, 4'h3, 16'h0000, "wr7_dout");
        rd(14'h0007, 16'h00AB, "rd7_partial_after_wipe");

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d checks left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
